// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: break-before-make direction/value sequencing plus input sync and edge IRQs.
// Optional feature macro: GPIO_PAD_CTRL_IRQ_EN builds edge detection, sticky status and irq_o.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a command; drivers and values stable
// ST_BREAK | drivers turning off have been released; held SETTLE cycles
// ST_VALUE | new output values applied to masked pins; held SETTLE cycles
// ST_MAKE  | drivers turning on have been enabled; held SETTLE cycles

module gpio_pad_ctrl #(
    parameter int NGPIO  = 62,
    parameter int SETTLE = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [NGPIO-1:0] cmd_mask_i,
    input  logic [NGPIO-1:0] cmd_dir_i,
    input  logic [NGPIO-1:0] cmd_out_i,
    output logic [NGPIO-1:0] gpio_dir_o,
    output logic [NGPIO-1:0] gpio_out_o,
    input  logic [NGPIO-1:0] gpio_in_i,
    output logic [NGPIO-1:0] gpio_in_sync_o,
    input  logic [NGPIO-1:0] irq_rise_en_i,
    input  logic [NGPIO-1:0] irq_fall_en_i,
    input  logic [NGPIO-1:0] irq_clr_i,
    output logic [NGPIO-1:0] irq_status_o,
    output logic             irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_VALUE = 2'd2,
        ST_MAKE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             ready_q;
    logic [NGPIO-1:0] dir_q;
    logic [NGPIO-1:0] out_q;
    logic [NGPIO-1:0] mask_q;
    logic [NGPIO-1:0] out_new_q;
    logic [NGPIO-1:0] on_q;

    logic [NGPIO-1:0] off_d;
    logic [NGPIO-1:0] on_d;
    logic [NGPIO-1:0] out_d;

    // OFF/ON are taken against the direction register at acceptance.
    assign off_d = cmd_mask_i & dir_q & ~cmd_dir_i;
    assign on_d  = cmd_mask_i & ~dir_q & cmd_dir_i;
    assign out_d = (out_q & ~mask_q) | (out_new_q & mask_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b1;
            dir_q     <= '0;
            out_q     <= '0;
            mask_q    <= '0;
            out_new_q <= '0;
            on_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        mask_q    <= cmd_mask_i;
                        out_new_q <= cmd_out_i;
                        on_q      <= on_d;
                        dir_q     <= dir_q & ~off_d;
                        ready_q   <= 1'b0;
                        cnt_q     <= CNT_LOAD;
                        state_q   <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == 4'd0) begin
                        out_q   <= out_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_VALUE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_VALUE: begin
                    if (cnt_q == 4'd0) begin
                        dir_q   <= dir_q | on_q;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_MAKE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_MAKE: begin
                    if (cnt_q == 4'd0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign gpio_dir_o  = dir_q;
    assign gpio_out_o  = out_q;

    logic [NGPIO-1:0] sync1_q;
    logic [NGPIO-1:0] sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign gpio_in_sync_o = sync2_q;

`ifdef GPIO_PAD_CTRL_IRQ_EN
    logic [NGPIO-1:0] hist_q;
    logic [NGPIO-1:0] status_q;
    logic [NGPIO-1:0] status_d;
    logic [NGPIO-1:0] set_d;

    // A new edge outranks a clear arriving in the same cycle.
    assign set_d    = ((sync2_q & ~hist_q) & irq_rise_en_i) | ((~sync2_q & hist_q) & irq_fall_en_i);
    assign status_d = (status_q & ~irq_clr_i) | set_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q   <= '0;
            status_q <= '0;
        end else begin
            hist_q   <= sync2_q;
            status_q <= status_d;
        end
    end

    assign irq_status_o = status_q;
    assign irq_o        = |status_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_rise_en_i, irq_fall_en_i, irq_clr_i};
    assign irq_status_o      = '0;
    assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: command sequencing via an expectation queue, reset abort, input sync/IRQ.
module tb_gpio_pad_ctrl;

    localparam int NGPIO  = 62;
    localparam int SETTLE = 2;
    localparam int LAT    = 3 * SETTLE + 1;
`ifdef GPIO_PAD_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [NGPIO-1:0] cmd_mask_i;
    logic [NGPIO-1:0] cmd_dir_i;
    logic [NGPIO-1:0] cmd_out_i;
    logic [NGPIO-1:0] gpio_dir_o;
    logic [NGPIO-1:0] gpio_out_o;
    logic [NGPIO-1:0] gpio_in_i;
    logic [NGPIO-1:0] gpio_in_sync_o;
    logic [NGPIO-1:0] irq_rise_en_i;
    logic [NGPIO-1:0] irq_fall_en_i;
    logic [NGPIO-1:0] irq_clr_i;
    logic [NGPIO-1:0] irq_status_o;
    logic             irq_o;

    gpio_pad_ctrl #(.NGPIO(NGPIO), .SETTLE(SETTLE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mask_i(cmd_mask_i), .cmd_dir_i(cmd_dir_i), .cmd_out_i(cmd_out_i),
        .gpio_dir_o(gpio_dir_o), .gpio_out_o(gpio_out_o),
        .gpio_in_i(gpio_in_i), .gpio_in_sync_o(gpio_in_sync_o),
        .irq_rise_en_i(irq_rise_en_i), .irq_fall_en_i(irq_fall_en_i),
        .irq_clr_i(irq_clr_i), .irq_status_o(irq_status_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NGPIO-1:0] dir;
        logic [NGPIO-1:0] out;
        logic             rdy;
    } snap_t;

    snap_t            sb_q[$];
    logic [NGPIO-1:0] dir_m;
    logic [NGPIO-1:0] out_m;
    logic [NGPIO-1:0] one;
    int               n_chk;
    int               n_pass;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Model of the break/value/make sequence; pushes one snapshot per cycle after acceptance.
    task automatic run_cmd(input string tag, input logic [NGPIO-1:0] m, input logic [NGPIO-1:0] d,
                           input logic [NGPIO-1:0] o, input bit hold, input int n);
        logic [NGPIO-1:0] off, on, dir1, out1, dir2;
        snap_t s;
        snap_t e;
        off  = m & dir_m & ~d;
        on   = m & ~dir_m & d;
        dir1 = dir_m & ~off;
        out1 = (out_m & ~m) | (o & m);
        dir2 = dir1 | on;
        for (int k = 1; k <= LAT; k++) begin
            s.dir = (k <= 2 * SETTLE) ? dir1 : dir2;
            s.out = (k <= SETTLE) ? out_m : out1;
            s.rdy = (k == LAT);
            sb_q.push_back(s);
        end
        dir_m = dir2;
        out_m = out1;
        cmd_mask_i  = m;
        cmd_dir_i   = d;
        cmd_out_i   = o;
        cmd_valid_i = 1'b1;
        tick();
        if (!hold) begin
            cmd_valid_i = 1'b0;
            cmd_mask_i  = '1;
            cmd_dir_i   = ~d;
            cmd_out_i   = ~o;
        end
        for (int k = 1; k <= n; k++) begin
            if (k > 1) tick();
            e = sb_q.pop_front();
            chk($sformatf("%s dir T+%0d", tag, k), 64'(gpio_dir_o), 64'(e.dir));
            chk($sformatf("%s out T+%0d", tag, k), 64'(gpio_out_o), 64'(e.out));
            chk($sformatf("%s ready T+%0d", tag, k), 64'(cmd_ready_o), 64'(e.rdy));
        end
    endtask

    initial begin
        logic [NGPIO-1:0] b3;
        logic [NGPIO-1:0] exp3;
        n_chk = 0;
        n_pass = 0;
        one = 1;
        b3 = one << 3;
        exp3 = IRQ_ON ? b3 : '0;
        dir_m = '0;
        out_m = '0;
        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_mask_i = '0;
        cmd_dir_i = '0;
        cmd_out_i = '0;
        gpio_in_i = '0;
        irq_rise_en_i = '0;
        irq_fall_en_i = '0;
        irq_clr_i = '0;
        tick();
        tick();
        chk("rst dir", 64'(gpio_dir_o), 64'd0);
        chk("rst out", 64'(gpio_out_o), 64'd0);
        chk("rst ready", 64'(cmd_ready_o), 64'd1);
        chk("rst sync", 64'(gpio_in_sync_o), 64'd0);
        chk("rst status", 64'(irq_status_o), 64'd0);
        chk("rst irq", 64'(irq_o), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("idle ready", 64'(cmd_ready_o), 64'd1);

        run_cmd("p5_on", one << 5, one << 5, one << 5, 1'b0, LAT);
        run_cmd("p7_on", one << 7, one << 7, one << 7, 1'b0, LAT);
        run_cmd("p7_off", one << 7, '0, '0, 1'b0, LAT);
        run_cmd("mask0", '0, '1, '1, 1'b0, LAT);
        run_cmd("mixed", 62'h0000_0000_0000_FFFF, 62'h0000_0000_0000_5A5A, 62'h0000_0000_0000_C3C3, 1'b0, LAT);

        run_cmd("b2b_a", 62'h0000_0000_3FF0_0000, 62'h0000_0000_3FF0_0000, 62'h0000_0000_1550_0000, 1'b1, LAT);
        run_cmd("b2b_b", (one << 5) | (one << 25), '0, (one << 25), 1'b0, LAT);

        run_cmd("p9_abort", one << 9, one << 9, one << 9, 1'b0, 2 * SETTLE + 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_make rst dir", 64'(gpio_dir_o), 64'd0);
        chk("mid_make rst out", 64'(gpio_out_o), 64'd0);
        chk("mid_make rst ready", 64'(cmd_ready_o), 64'd1);
        sb_q.delete();
        dir_m = '0;
        out_m = '0;
        tick();
        rst_i = 1'b0;
        tick();
        chk("post_rst ready", 64'(cmd_ready_o), 64'd1);
        run_cmd("post_rst", one << 2, one << 2, one << 2, 1'b0, LAT);

        irq_rise_en_i = b3;
        gpio_in_i[3] = 1'b1;
        gpio_in_i[10] = 1'b1;
        tick();
        chk("sync e1", 64'(gpio_in_sync_o), 64'd0);
        chk("status e1", 64'(irq_status_o), 64'd0);
        tick();
        chk("sync e2", 64'(gpio_in_sync_o), 64'(b3 | (one << 10)));
        chk("status e2", 64'(irq_status_o), 64'd0);
        tick();
        chk("status e3", 64'(irq_status_o), 64'(exp3));
        chk("irq e3", 64'(irq_o), 64'(IRQ_ON));
        irq_clr_i = b3;
        tick();
        irq_clr_i = '0;
        chk("status clr", 64'(irq_status_o), 64'd0);
        chk("irq clr", 64'(irq_o), 64'd0);
        gpio_in_i[3] = 1'b0;
        tick();
        tick();
        tick();
        chk("sync fall", 64'(gpio_in_sync_o), 64'(one << 10));
        chk("status no fall_en", 64'(irq_status_o), 64'd0);
        gpio_in_i[3] = 1'b1;
        tick();
        tick();
        irq_clr_i = b3;
        tick();
        irq_clr_i = '0;
        chk("set beats clr", 64'(irq_status_o), 64'(exp3));
        tick();
        chk("status sticky", 64'(irq_status_o), 64'(exp3));
        chk("irq sticky", 64'(irq_o), 64'(IRQ_ON));
        irq_clr_i = b3;
        irq_fall_en_i = b3;
        tick();
        irq_clr_i = '0;
        gpio_in_i[3] = 1'b0;
        tick();
        tick();
        chk("status pre fall", 64'(irq_status_o), 64'd0);
        tick();
        chk("status fall", 64'(irq_status_o), 64'(exp3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
